// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_if
// Brief    : AXI4 slave bus bundle for the interrupt controller. The
//            controller side uses the slave modport, the bus owner uses the
//            master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if #(
    parameter int WIDTH_ID = 2,
    parameter int WIDTH_DA = 32,
    parameter int WIDTH_AD = 32
);
    // write address channel
    logic [WIDTH_ID-1:0]   S_AXI_AWID;
    logic [WIDTH_AD-1:0]   S_AXI_AWADDR;
    logic [3:0]            S_AXI_AWLEN;
    logic [2:0]            S_AXI_AWSIZE;
    logic [1:0]            S_AXI_AWBURST;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    // write data channel
    logic [WIDTH_DA-1:0]   S_AXI_WDATA;
    logic [WIDTH_DA/8-1:0] S_AXI_WSTRB;
    logic                  S_AXI_WLAST;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    // write response channel
    logic [WIDTH_ID-1:0]   S_AXI_BID;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    // read address channel
    logic [WIDTH_ID-1:0]   S_AXI_ARID;
    logic [WIDTH_AD-1:0]   S_AXI_ARADDR;
    logic [3:0]            S_AXI_ARLEN;
    logic [2:0]            S_AXI_ARSIZE;
    logic [1:0]            S_AXI_ARBURST;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    // read data channel
    logic [WIDTH_ID-1:0]   S_AXI_RID;
    logic [WIDTH_DA-1:0]   S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RLAST;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : AXI4 memory-mapped interrupt controller. Latches source lines as
//            pending, masks them with enables, raises one request to the core
//            and hands sources out through a claim/complete handshake.
//            Map (addr[3:0]): 0x0 PENDING, 0x4 ENABLE, 0x8 CLAIM, 0xC EDGE.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int WIDTH_ID = 2,
    parameter int WIDTH_DA = 32,
    parameter int WIDTH_AD = 32,
    parameter int N_SRC    = 8
) (
    input  wire             S_AXI_ACLK,
    input  wire             S_AXI_ARESET,
    irq_ctrl_if.slave       s_axi,
    input  wire [N_SRC-1:0] irq_src_i,
    output logic            irq_o
);

    localparam logic [3:0] c_off_pending = 4'h0;
    localparam logic [3:0] c_off_enable  = 4'h4;
    localparam logic [3:0] c_off_claim   = 4'h8;
    localparam logic [3:0] c_off_edge    = 4'hC;
    localparam logic [1:0] c_resp_okay   = 2'b00;

    localparam logic [1:0] c_w_idle = 2'd0;
    localparam logic [1:0] c_w_data = 2'd1;
    localparam logic [1:0] c_w_resp = 2'd2;
    localparam logic       c_r_idle = 1'b0;
    localparam logic       c_r_data = 1'b1;

    // interrupt state
    logic [N_SRC-1:0]    r_pending;
    logic [N_SRC-1:0]    r_enable;
    logic [N_SRC-1:0]    r_edge;
    logic [N_SRC-1:0]    r_in_service;
    logic [N_SRC-1:0]    r_prev;
    logic                r_irq;

    // write channel
    logic [1:0]          r_wstate;
    logic [1:0]          w_wstate_nxt;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [3:0]          r_awaddr;
    logic [WIDTH_ID-1:0] r_awid;

    // read channel
    logic                r_rstate;
    logic                w_rstate_nxt;
    logic                r_arready;
    logic                r_rvalid;
    logic [WIDTH_DA-1:0] r_rdata;
    logic [WIDTH_DA-1:0] w_rdata;
    logic [WIDTH_ID-1:0] r_rid;

    logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                w_wr_enable, w_wr_edge, w_wr_claim, w_claim_rd;
    logic [4:0]          w_cmp_id;
    logic [4:0]          w_claim_id;
    logic [N_SRC-1:0]    w_trig;
    logic [N_SRC-1:0]    w_active;
    logic [N_SRC-1:0]    w_claim_oh;
    logic [N_SRC-1:0]    w_claim_clr;
    logic [N_SRC-1:0]    w_cmp_clr;
    logic                w_unused;

    assign w_aw_hs = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  & r_wready;
    assign w_b_hs  = r_bvalid & s_axi.S_AXI_BREADY;
    assign w_ar_hs = s_axi.S_AXI_ARVALID & r_arready;
    assign w_r_hs  = r_rvalid & s_axi.S_AXI_RREADY;

    // register writes act at the address latched from AW
    assign w_wr_enable = w_w_hs & (r_awaddr == c_off_enable);
    assign w_wr_edge   = w_w_hs & (r_awaddr == c_off_edge);
    assign w_wr_claim  = w_w_hs & (r_awaddr == c_off_claim);
    assign w_cmp_id    = s_axi.S_AXI_WDATA[4:0];

    // a claim is the AR handshake itself, not the later R beat
    assign w_claim_rd  = w_ar_hs & (s_axi.S_AXI_ARADDR[3:0] == c_off_claim);

    // edge mode compares against last cycle; prev is 0 out of reset, so a
    // source held high across reset release counts as a rising edge
    assign w_trig   = irq_src_i & (~r_edge | ~r_prev);
    assign w_active = r_pending & r_enable;

    // lowest-index active source wins the claim
    always_comb begin
        w_claim_oh = '0;
        w_claim_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_claim_oh    = '0;
                w_claim_oh[i] = 1'b1;
                w_claim_id    = 5'(i + 1);
            end
        end
    end

    assign w_claim_clr = w_claim_rd ? w_claim_oh : '0;

    // complete decode; IDs 0 and above N_SRC match no source and are dropped
    always_comb begin
        w_cmp_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_cmp_clr[i] = w_wr_claim & (w_cmp_id == 5'(i + 1));
        end
    end

    // pending/in-service/config state; a claim beats a same-cycle trigger
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_pending    <= '0;
            r_enable     <= '0;
            r_edge       <= '0;
            r_in_service <= '0;
            r_prev       <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_prev       <= irq_src_i;
            r_pending    <= (r_pending | (w_trig & ~r_in_service)) & ~w_claim_clr;
            r_in_service <= (r_in_service & ~w_cmp_clr) | w_claim_clr;
            r_irq        <= |w_active;
            if (w_wr_enable) begin
                r_enable <= s_axi.S_AXI_WDATA[N_SRC-1:0];
            end
            if (w_wr_edge) begin
                r_edge <= s_axi.S_AXI_WDATA[N_SRC-1:0];
            end
        end
    end

    assign irq_o = r_irq;

    // write FSM next-state
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_w_idle: if (w_aw_hs) w_wstate_nxt = c_w_data;
            c_w_data: if (w_w_hs && s_axi.S_AXI_WLAST) w_wstate_nxt = c_w_resp;
            c_w_resp: if (w_b_hs) w_wstate_nxt = c_w_idle;
            default:  w_wstate_nxt = c_w_idle;
        endcase
    end

    // write FSM state and registered handshake outputs
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate  <= c_w_idle;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == c_w_idle);
            r_wready  <= (w_wstate_nxt == c_w_data);
            r_bvalid  <= (w_wstate_nxt == c_w_resp);
            if (w_aw_hs) begin
                r_awaddr <= s_axi.S_AXI_AWADDR[3:0];
                r_awid   <= s_axi.S_AXI_AWID;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BID     = r_awid;
    assign s_axi.S_AXI_BRESP   = c_resp_okay;

    // read data mux; unmapped offsets read 0
    always_comb begin
        w_rdata = '0;
        case (s_axi.S_AXI_ARADDR[3:0])
            c_off_pending: w_rdata = WIDTH_DA'(r_pending);
            c_off_enable:  w_rdata = WIDTH_DA'(r_enable);
            c_off_claim:   w_rdata = WIDTH_DA'(w_claim_id);
            c_off_edge:    w_rdata = WIDTH_DA'(r_edge);
            default:       w_rdata = '0;
        endcase
    end

    // read FSM next-state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_r_idle: if (w_ar_hs) w_rstate_nxt = c_r_data;
            c_r_data: if (w_r_hs)  w_rstate_nxt = c_r_idle;
            default:  w_rstate_nxt = c_r_idle;
        endcase
    end

    // read FSM state, registered handshake outputs and held read beat
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate  <= c_r_idle;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == c_r_idle);
            r_rvalid  <= (w_rstate_nxt == c_r_data);
            if (w_ar_hs) begin
                r_rdata <= w_rdata;
                r_rid   <= s_axi.S_AXI_ARID;
            end
        end
    end

    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RID     = r_rid;
    assign s_axi.S_AXI_RLAST   = r_rvalid;
    assign s_axi.S_AXI_RRESP   = c_resp_okay;

    // burst attributes, strobes and upper address/data bits carry no meaning here
    assign w_unused = &{1'b0,
                        s_axi.S_AXI_AWLEN, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST,
                        s_axi.S_AXI_AWADDR[WIDTH_AD-1:0], s_axi.S_AXI_WSTRB,
                        s_axi.S_AXI_WDATA, s_axi.S_AXI_ARLEN, s_axi.S_AXI_ARSIZE,
                        s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARADDR[WIDTH_AD-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Brief    : Directed self-checking bench for irq_ctrl (N_SRC = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  src;
    logic        irq;
    int          n_vec;
    int          n_err;
    logic [31:0] rd;
    logic        rd_last;
    logic [1:0]  rd_id;

    irq_ctrl_if #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32)) bus ();

    irq_ctrl #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32), .N_SRC(8)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .irq_src_i    (src),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int bready_delay);
        int n;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWID    = 2'd1;
        bus.S_AXI_AWLEN   = 4'd0;
        bus.S_AXI_AWSIZE  = 3'd2;
        bus.S_AXI_AWBURST = 2'b01;
        bus.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin tick(); n++; end
        if (n >= 20) check_eq("awready_timeout", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WLAST   = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        n = 0;
        while (!bus.S_AXI_WREADY && n < 20) begin tick(); n++; end
        if (n >= 20) check_eq("wready_timeout", {31'd0, bus.S_AXI_WREADY}, 32'd1);
        tick();
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_WLAST   = 1'b0;
        for (int k = 0; k < bready_delay; k++) begin
            check_eq("bvalid_hold", {31'd0, bus.S_AXI_BVALID}, 32'd1);
            check_eq("awready_busy", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
            tick();
        end
        bus.S_AXI_BREADY = 1'b1;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin tick(); n++; end
        if (n >= 20) check_eq("bvalid_timeout", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check_eq("bid", {30'd0, bus.S_AXI_BID}, 32'd1);
        check_eq("bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        tick();
        bus.S_AXI_BREADY = 1'b0;
        if (bready_delay > 0) begin
            check_eq("bvalid_clear", {31'd0, bus.S_AXI_BVALID}, 32'd0);
            check_eq("awready_back", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARID    = 2'd2;
        bus.S_AXI_ARLEN   = 4'd0;
        bus.S_AXI_ARSIZE  = 3'd2;
        bus.S_AXI_ARBURST = 2'b01;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
        if (n >= 20) check_eq("arready_timeout", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin tick(); n++; end
        if (n >= 20) check_eq("rvalid_timeout", {31'd0, bus.S_AXI_RVALID}, 32'd1);
        data    = bus.S_AXI_RDATA;
        rd_last = bus.S_AXI_RLAST;
        rd_id   = bus.S_AXI_RID;
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] mask, input int cycles);
        src = src | mask;
        repeat (cycles) tick();
        src = src & ~mask;
    endtask

    initial begin
        logic [31:0] offs [4];
        offs = '{32'h0, 32'h4, 32'h8, 32'hC};
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        src = '0;
        bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0;
        bus.S_AXI_AWSIZE = '0; bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARSIZE = '0; bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (3) tick();

        // reset state
        check_eq("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
        check_eq("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
        check_eq("rst_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
        check_eq("rst_rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd0);
        check_eq("rst_irq",     {31'd0, irq}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: all registers read 0, single beat echoing ARID
        for (int i = 0; i < 4; i++) begin
            axi_read(offs[i], rd);
            check_eq($sformatf("t1_reg_%0h", offs[i]), rd, 32'd0);
            check_eq("t1_rlast", {31'd0, rd_last}, 32'd1);
            check_eq("t1_rid", {30'd0, rd_id}, 32'd2);
        end
        check_eq("t1_irq", {31'd0, irq}, 32'd0);

        // 2: level source 0, claim, complete while still high
        axi_write(32'h4, 32'h1, 0);
        src[0] = 1'b1;
        tick();
        check_eq("t2_irq_pend_edge", {31'd0, irq}, 32'd0);
        tick();
        check_eq("t2_irq_next", {31'd0, irq}, 32'd1);
        axi_read(32'h8, rd);
        check_eq("t2_claim", rd, 32'd1);
        check_eq("t2_irq_drop", {31'd0, irq}, 32'd0);
        axi_read(32'h0, rd);
        check_eq("t2_pend_in_service", rd, 32'd0);
        axi_write(32'h8, 32'd1, 0);
        axi_read(32'h0, rd);
        check_eq("t2_repend", rd, 32'h1);
        check_eq("t2_irq_repend", {31'd0, irq}, 32'd1);
        src[0] = 1'b0;
        axi_read(32'h8, rd);
        check_eq("t2_claim2", rd, 32'd1);
        axi_write(32'h8, 32'd1, 0);

        // 3: priority among sources 3 and 5; enable upper bits read 0
        axi_write(32'h4, 32'hFFFF_FFFF, 0);
        axi_read(32'h4, rd);
        check_eq("t3_enable", rd, 32'hFF);
        pulse(8'h28, 1);
        axi_read(32'h0, rd);
        check_eq("t3_pending", rd, 32'h28);
        axi_read(32'h8, rd);
        check_eq("t3_claim_a", rd, 32'd4);
        axi_read(32'h8, rd);
        check_eq("t3_claim_b", rd, 32'd6);
        axi_read(32'h8, rd);
        check_eq("t3_claim_none", rd, 32'd0);
        check_eq("t3_irq", {31'd0, irq}, 32'd0);
        axi_write(32'h8, 32'd4, 0);
        axi_write(32'h8, 32'd6, 0);

        // 4: edge-triggered source 1
        axi_write(32'hC, 32'h2, 0);
        axi_read(32'hC, rd);
        check_eq("t4_edge", rd, 32'h2);
        pulse(8'h02, 3);
        axi_read(32'h0, rd);
        check_eq("t4_single", rd, 32'h2);
        axi_read(32'h8, rd);
        check_eq("t4_claim", rd, 32'd2);
        pulse(8'h02, 3);
        axi_read(32'h0, rd);
        check_eq("t4_dropped", rd, 32'h0);
        axi_write(32'h8, 32'd2, 0);
        axi_read(32'h0, rd);
        check_eq("t4_no_level_repend", rd, 32'h0);
        pulse(8'h02, 1);
        axi_read(32'h0, rd);
        check_eq("t4_new_pulse", rd, 32'h2);
        axi_read(32'h8, rd);
        check_eq("t4_claim2", rd, 32'd2);
        axi_write(32'h8, 32'd2, 0);

        // 5: masking source 2, invalid completes
        axi_write(32'h4, 32'h0, 0);
        pulse(8'h04, 1);
        axi_read(32'h0, rd);
        check_eq("t5_pending", rd, 32'h4);
        check_eq("t5_irq_masked", {31'd0, irq}, 32'd0);
        axi_write(32'h4, 32'h4, 0);
        check_eq("t5_irq_on", {31'd0, irq}, 32'd1);
        axi_write(32'h4, 32'h0, 0);
        check_eq("t5_irq_off", {31'd0, irq}, 32'd0);
        axi_read(32'h0, rd);
        check_eq("t5_pend_kept", rd, 32'h4);
        axi_write(32'h4, 32'h4, 0);
        axi_read(32'h8, rd);
        check_eq("t5_claim", rd, 32'd3);
        axi_write(32'h8, 32'd0, 0);
        axi_write(32'h8, 32'd9, 0);
        pulse(8'h04, 1);
        axi_read(32'h0, rd);
        check_eq("t5_still_in_service", rd, 32'h0);
        axi_write(32'h8, 32'd3, 0);
        pulse(8'h04, 1);
        axi_read(32'h0, rd);
        check_eq("t5_after_complete", rd, 32'h4);
        axi_read(32'h8, rd);
        check_eq("t5_claim2", rd, 32'd3);
        axi_write(32'h8, 32'd3, 0);

        // 6: write response back-pressure, then reset during a read
        axi_write(32'h4, 32'h5, 5);
        bus.S_AXI_ARADDR  = 32'h4;
        bus.S_AXI_ARID    = 2'd3;
        bus.S_AXI_ARVALID = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
            if (n >= 20) check_eq("t6_arready_timeout", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
        end
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check_eq("t6_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
        check_eq("t6_rdata", bus.S_AXI_RDATA, 32'h5);
        check_eq("t6_rid", {30'd0, bus.S_AXI_RID}, 32'd3);
        rst = 1'b1;
        tick();
        check_eq("t6_rvalid_abort", {31'd0, bus.S_AXI_RVALID}, 32'd0);
        check_eq("t6_arready_rst", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
        rst = 1'b0;
        tick();
        axi_read(32'h4, rd);
        check_eq("t6_enable_cleared", rd, 32'h0);
        axi_read(32'hC, rd);
        check_eq("t6_edge_cleared", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- AXI4 memory-mapped interrupt controller; sits directly downstream of the timer and the other peripheral interrupt outputs.
- Latches up to N_SRC interrupt source lines as pending and masks them with enable bits.
- Drives one request line to the core.
- Uses a claim/complete protocol, so firmware services one source at a time and level sources do not re-fire while in service.

Parameters:
- WIDTH_ID, 2, AXI ID width
- WIDTH_DA, 32, AXI data width; registers are 32 bits
- WIDTH_AD, 32, AXI address width
- N_SRC, 8, number of interrupt sources, legal range 1..31; source i has ID i+1

Ports:
- S_AXI_ACLK  in  1  the single clock
- S_AXI_ARESET  in  1  synchronous, active-high reset
- S_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  in  WIDTH_ID/WIDTH_AD/4/3/2/1  write address
- S_AXI_AWREADY  out  1
- S_AXI_W{DATA,STRB,LAST,VALID}  in  WIDTH_DA/WIDTH_DA/8/1/1  write data
- S_AXI_WREADY  out  1
- S_AXI_B{ID,RESP,VALID}  out  WIDTH_ID/2/1  write response
- S_AXI_BREADY  in  1
- S_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  in  WIDTH_ID/WIDTH_AD/4/3/2/1  read address
- S_AXI_ARREADY  out  1
- S_AXI_R{ID,DATA,RESP,LAST,VALID}  out  WIDTH_ID/WIDTH_DA/2/1/1  read data
- S_AXI_RREADY  in  1
- irq_src_i  in  N_SRC  source lines, synchronous to S_AXI_ACLK; bit 0 is the timer interrupt
- irq_o  out  1  interrupt request to the core, registered

Behaviour:
- Register map, decoded on addr[3:0]; upper address bits are ignored:
  - 0x0 PENDING: read-only; writes are ignored.
  - 0x4 ENABLE: read/write; bits above N_SRC-1 read 0.
  - 0x8 CLAIM: a read returns the claimed ID. A write is a complete for source ID WDATA[4:0].
  - 0xC EDGE: read/write; 1 = rising-edge triggered, 0 = level triggered.
  - Unmapped offsets read 0 with OKAY; writes to them are ignored.
  - WSTRB is ignored; a write is always a full-word write.
- Reset values: pending, enable, edge, in_service and the prev-source register are all 0. irq_o=0. All VALID/READY outputs are 0. BRESP/RRESP/RID/BID/RDATA are 0.
- Trigger for source i:
  - Edge mode: trig = src[i] & ~prev[i], with prev registered every cycle.
  - Level mode: trig = src[i].
  - A source held high across reset release produces an edge on the first cycle.
- Pending set/clear:
  - pending[i] sets when trig is high and in_service[i] is 0.
  - A trigger while in service is dropped.
  - pending[i] clears only by a claim.
- irq_o: registered OR of (pending & enable); one-cycle latency from pending/enable change.
- Claim:
  - Happens at the AR handshake cycle when ARADDR[3:0]=0x8.
  - Winner: lowest index i with pending & enable set.
  - RDATA = i+1; pending[i] is cleared and in_service[i] is set in that same edge.
  - If there is no winner, RDATA = 0 with no side effects.
  - If a source triggers in the claim cycle for the claimed index, the claim wins: pending ends at 0 and in_service at 1.
- Complete:
  - A W beat to 0x8 with 1 <= ID <= N_SRC clears in_service[ID-1].
  - Any other ID is ignored.
  - A level source still high re-pends on the following cycle.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch AWADDR and AWID and go to W_DATA.
  - W_DATA: WREADY=1. Each accepted beat performs the register write at the latched address. On the beat with WLAST, set BVALID and go to W_RESP.
  - W_RESP: BID = latched AWID, BRESP = OKAY. Hold BVALID until BREADY, then go to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, register RDATA, set RVALID=1 and RLAST=1, RID = ARID, and go to R_DATA.
  - R_DATA: hold RVALID, RDATA and RID stable until RREADY, then go to R_IDLE.
  - ARLEN is ignored; every read returns exactly one beat.
- Read and write channels are independent. A claim and a complete in the same cycle always act on different sources, since a pending source is never in service.
- Reset asserted mid-transaction aborts both FSMs to idle and clears all state on the next edge; no response is issued for the aborted transaction.

Test Plan:
1. Reset, then read all four registers -> 0 each; irq_o=0; RLAST=1; RID echoes ARID=2.
2. ENABLE=0x1, level source 0 held high -> irq_o=1 one cycle after pending sets. Read CLAIM -> 1; pending=0; irq_o drops. Complete with ID 1 while src still high -> PENDING bit 0 reads 1 again.
3. Sources 3 and 5 pending, ENABLE=0xFF -> first CLAIM returns 4, second returns 6, third returns 0.
4. EDGE=0x2, pulse src[1] for 3 cycles -> a single pending. Re-pulse while in service -> dropped. After complete, a new pulse -> pends again.
5. Enable source 2 with pending set -> irq_o=1. ENABLE=0 -> irq_o=0 with pending retained. Complete with IDs 0 and 9 -> no state change.
6. BREADY held low 5 cycles after a write -> BVALID stays 1 and AWREADY=0 until BREADY. Assert reset mid-read -> RVALID=0 after the edge.
